stack_arbiter: RTL and testbench

- Shares one 16-entry, 32-bit LIFO stack between two requesters, A and B.
- Each requester has a push/pop strobe-ack handshake; arbitration is round-robin.
- Block issues single-cycle PUSH/POP strobes to the stack and captures registered pop data.
- Tracks occupancy itself; full-push and empty-pop are rejected with an error flag and never reach the stack.

---
 rtl/stack_arbiter_pkg.sv | 25 ++
 rtl/stack_arbiter_if.sv | 45 ++++
 rtl/stack_arbiter_rr_arb2.sv | 33 +++
 rtl/stack_arbiter.sv | 151 +++++++++++++++
 tb/tb_stack_arbiter.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_arbiter_pkg.sv
// Shared types and defaults for the two-client LIFO stack arbiter.
package stack_arb_pkg;

  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned LW_DEF    = 5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_e;

  typedef enum logic {
    CL_A = 1'b0,
    CL_B = 1'b1
  } client_e;

  typedef enum logic {
    OP_PUSH = 1'b0,
    OP_POP  = 1'b1
  } op_e;

endpackage

// File: rtl/stack_arbiter_if.sv
// Client handshakes and stack strobe bus; slave = arbiter side, master = clients/stack side.
interface stack_arbiter_if
  import stack_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF
);

  logic          A_PUSH_STB;
  logic          A_POP_STB;
  logic [DW-1:0] A_DAT_IN;
  logic          A_ACK;
  logic          A_ERR;
  logic [DW-1:0] A_DAT_OUT;

  logic          B_PUSH_STB;
  logic          B_POP_STB;
  logic [DW-1:0] B_DAT_IN;
  logic          B_ACK;
  logic          B_ERR;
  logic [DW-1:0] B_DAT_OUT;

  logic          S_PUSH_STB;
  logic [DW-1:0] S_PUSH_DAT;
  logic          S_POP_STB;
  logic [DW-1:0] S_POP_DAT;

  modport slave (
    input  A_PUSH_STB, A_POP_STB, A_DAT_IN,
    input  B_PUSH_STB, B_POP_STB, B_DAT_IN,
    input  S_POP_DAT,
    output A_ACK, A_ERR, A_DAT_OUT,
    output B_ACK, B_ERR, B_DAT_OUT,
    output S_PUSH_STB, S_PUSH_DAT, S_POP_STB
  );

  modport master (
    output A_PUSH_STB, A_POP_STB, A_DAT_IN,
    output B_PUSH_STB, B_POP_STB, B_DAT_IN,
    output S_POP_DAT,
    input  A_ACK, A_ERR, A_DAT_OUT,
    input  B_ACK, B_ERR, B_DAT_OUT,
    input  S_PUSH_STB, S_PUSH_DAT, S_POP_STB
  );

endinterface

// File: rtl/stack_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; priority flips to the loser after each advanced grant.
module rr_arb2
  import stack_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  client_e prio_q, prio_d;

  always_comb begin
    grant  = req;
    if (req == 2'b11) begin
      grant = (prio_q == CL_A) ? 2'b01 : 2'b10;
    end
    prio_d = prio_q;
    if (advance && (grant != '0)) begin
      prio_d = grant[0] ? CL_B : CL_A;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= CL_A;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one LIFO stack between clients A and B; rejects full-push / empty-pop locally.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int unsigned DW    = DW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned LW    = LW_DEF
) (
  input  logic           CLK,
  input  logic           RST_N,
  stack_arbiter_if.slave bus,
  output logic [LW-1:0]  LEVEL,
  output logic           FULL,
  output logic           EMPTY
);

  state_e        state_q, state_d;
  client_e       client_q, client_d;
  op_e           op_q, op_d;
  logic [LW-1:0] level_q, level_d;
  logic [DW-1:0] s_push_dat_q, s_push_dat_d;
  logic [DW-1:0] a_dat_q, a_dat_d, b_dat_q, b_dat_d;
  logic          s_push_stb_q, s_push_stb_d, s_pop_stb_q, s_pop_stb_d;
  logic          a_ack_q, a_ack_d, a_err_q, a_err_d;
  logic          b_ack_q, b_ack_d, b_err_q, b_err_d;

  logic [1:0]    req, grant;
  logic          advance, full, empty, g_push;
  client_e       g_client;
  logic [DW-1:0] g_dat;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign req     = {bus.B_PUSH_STB | bus.B_POP_STB, bus.A_PUSH_STB | bus.A_POP_STB};
  assign advance = (state_q == IDLE) && (req != '0);

  rr_arb2 u_rr_arb2 (
    .clk     (CLK),
    .rst_n   (RST_N),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    g_client     = grant[1] ? CL_B : CL_A;
    g_push       = grant[1] ? bus.B_PUSH_STB : bus.A_PUSH_STB;
    g_dat        = grant[1] ? bus.B_DAT_IN : bus.A_DAT_IN;
    state_d      = state_q;
    client_d     = client_q;
    op_d         = op_q;
    level_d      = level_q;
    s_push_dat_d = s_push_dat_q;
    a_dat_d      = a_dat_q;
    b_dat_d      = b_dat_q;
    s_push_stb_d = 1'b0;
    s_pop_stb_d  = 1'b0;
    a_ack_d      = 1'b0;
    a_err_d      = 1'b0;
    b_ack_d      = 1'b0;
    b_err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (advance) begin
          client_d = g_client;
          op_d     = g_push ? OP_PUSH : OP_POP;
          if (g_push) s_push_dat_d = g_dat;
          // Rejected ops skip the stack and answer on the very next cycle.
          if (g_push ? full : empty) begin
            state_d = RESP;
            if (g_client == CL_A) begin
              a_ack_d = 1'b1;
              a_err_d = 1'b1;
              if (!g_push) a_dat_d = '0;
            end else begin
              b_ack_d = 1'b1;
              b_err_d = 1'b1;
              if (!g_push) b_dat_d = '0;
            end
          end else begin
            state_d      = ISSUE;
            s_push_stb_d = g_push;
            s_pop_stb_d  = !g_push;
          end
        end
      end
      ISSUE: begin
        level_d = (op_q == OP_PUSH) ? level_q + LW'(1) : level_q - LW'(1);
        state_d = CAPTURE;
      end
      CAPTURE: begin
        state_d = RESP;
        if (client_q == CL_A) begin
          a_ack_d = 1'b1;
          if (op_q == OP_POP) a_dat_d = bus.S_POP_DAT;
        end else begin
          b_ack_d = 1'b1;
          if (op_q == OP_POP) b_dat_d = bus.S_POP_DAT;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      client_q     <= CL_A;
      op_q         <= OP_PUSH;
      level_q      <= '0;
      s_push_dat_q <= '0;
      a_dat_q      <= '0;
      b_dat_q      <= '0;
      s_push_stb_q <= 1'b0;
      s_pop_stb_q  <= 1'b0;
      a_ack_q      <= 1'b0;
      a_err_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      b_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      client_q     <= client_d;
      op_q         <= op_d;
      level_q      <= level_d;
      s_push_dat_q <= s_push_dat_d;
      a_dat_q      <= a_dat_d;
      b_dat_q      <= b_dat_d;
      s_push_stb_q <= s_push_stb_d;
      s_pop_stb_q  <= s_pop_stb_d;
      a_ack_q      <= a_ack_d;
      a_err_q      <= a_err_d;
      b_ack_q      <= b_ack_d;
      b_err_q      <= b_err_d;
    end
  end

  assign bus.A_ACK      = a_ack_q;
  assign bus.A_ERR      = a_err_q;
  assign bus.A_DAT_OUT  = a_dat_q;
  assign bus.B_ACK      = b_ack_q;
  assign bus.B_ERR      = b_err_q;
  assign bus.B_DAT_OUT  = b_dat_q;
  assign bus.S_PUSH_STB = s_push_stb_q;
  assign bus.S_PUSH_DAT = s_push_dat_q;
  assign bus.S_POP_STB  = s_pop_stb_q;
  assign LEVEL          = level_q;
  assign FULL           = full;
  assign EMPTY          = empty;

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural 16-entry registered-output stack attached.
module tb_stack_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  level;
  logic        full, empty;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;

  stack_arbiter_if #(.DW(32)) bus ();

  stack_arbiter #(.DW(32), .DEPTH(16), .LW(5)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave),
    .LEVEL (level),
    .FULL  (full),
    .EMPTY (empty)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural stack: top-of-stack appears on S_POP_DAT one cycle after the pop strobe.
  logic [31:0] mem [16];
  int          sp = 0;
  logic [31:0] pop_dat = '0;
  assign bus.S_POP_DAT = pop_dat;

  always @(posedge clk) begin
    if (!rst_n) begin
      sp      <= 0;
      pop_dat <= '0;
    end else if (bus.S_PUSH_STB && sp < 16) begin
      mem[sp] <= bus.S_PUSH_DAT;
      sp      <= sp + 1;
    end else if (bus.S_POP_STB && sp > 0) begin
      pop_dat <= mem[sp-1];
      sp      <= sp - 1;
    end
  end

  int          push_cnt = 0, pop_cnt = 0, last_push_cyc = -1;
  logic [31:0] last_push_dat = '0;
  bit          prev_stb = 1'b0, adj_err = 1'b0, both_ack = 1'b0;

  always @(negedge clk) begin
    prev_stb <= bus.S_PUSH_STB | bus.S_POP_STB;
    if ((bus.S_PUSH_STB | bus.S_POP_STB) && prev_stb) adj_err <= 1'b1;
    if (bus.S_PUSH_STB && bus.S_POP_STB) adj_err <= 1'b1;
    if (bus.A_ACK && bus.B_ACK) both_ack <= 1'b1;
    if (bus.S_PUSH_STB) begin
      push_cnt      <= push_cnt + 1;
      last_push_cyc <= cyc;
      last_push_dat <= bus.S_PUSH_DAT;
    end
    if (bus.S_POP_STB) pop_cnt <= pop_cnt + 1;
  end

  task automatic drop_all();
    bus.A_PUSH_STB = 1'b0; bus.A_POP_STB = 1'b0;
    bus.B_PUSH_STB = 1'b0; bus.B_POP_STB = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drop_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one request from a client and waits (bounded) for its ACK; lat=-1 on timeout.
  task automatic run_op(input bit cl, input bit push, input logic [31:0] d,
                        output int t0, output int lat, output logic err, output logic [31:0] dout);
    @(negedge clk);
    if (!cl) begin
      bus.A_PUSH_STB = push; bus.A_POP_STB = !push; bus.A_DAT_IN = d;
    end else begin
      bus.B_PUSH_STB = push; bus.B_POP_STB = !push; bus.B_DAT_IN = d;
    end
    t0 = cyc; lat = -1; err = 1'bx; dout = 'x;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (cl ? bus.B_ACK : bus.A_ACK) begin
        lat  = cyc - t0;
        err  = cl ? bus.B_ERR : bus.A_ERR;
        dout = cl ? bus.B_DAT_OUT : bus.A_DAT_OUT;
        break;
      end
    end
    drop_all();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if ({empty, full} !== 2'b10) begin errors++; $display("FAIL reset_flags: got %b expected 10", {empty, full}); end
    checks++;
    if ({bus.A_ACK, bus.A_ERR, bus.B_ACK, bus.B_ERR, bus.S_PUSH_STB, bus.S_POP_STB} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
        {bus.A_ACK, bus.A_ERR, bus.B_ACK, bus.B_ERR, bus.S_PUSH_STB, bus.S_POP_STB});
    end
    checks++;
    if ({bus.A_DAT_OUT, bus.B_DAT_OUT, bus.S_PUSH_DAT} !== 96'h0) begin
      errors++; $display("FAIL reset_data: got %h %h %h expected zeros", bus.A_DAT_OUT, bus.B_DAT_OUT, bus.S_PUSH_DAT);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_push();
    int t0, lat; logic err; logic [31:0] dout;
    run_op(1'b0, 1'b1, 32'h1111_1111, t0, lat, err, dout);
    checks++; if (lat !== 3) begin errors++; $display("FAIL push_latency: got %0d expected 3", lat); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL push_err: got %b expected 0", err); end
    checks++; if (last_push_cyc !== t0 + 1) begin errors++; $display("FAIL push_strobe_cycle: got %0d expected %0d", last_push_cyc, t0 + 1); end
    checks++; if (last_push_dat !== 32'h1111_1111) begin errors++; $display("FAIL push_strobe_data: got %h expected 11111111", last_push_dat); end
    checks++; if ({level, empty} !== {5'd1, 1'b0}) begin errors++; $display("FAIL push_level: got %0d/%b expected 1/0", level, empty); end
  endtask

  task automatic test_lifo_order();
    int t0, lat; logic err; logic [31:0] dout;
    logic [31:0] exp_pop [4];
    exp_pop[0] = 32'hA2; exp_pop[1] = 32'hA1; exp_pop[2] = 32'hA0; exp_pop[3] = 32'h1111_1111;
    for (int i = 0; i < 3; i++) run_op(1'b0, 1'b1, 32'hA0 + 32'(i), t0, lat, err, dout);
    checks++; if (level !== 5'd4) begin errors++; $display("FAIL lifo_fill_level: got %0d expected 4", level); end
    for (int i = 0; i < 4; i++) begin
      run_op(1'b1, 1'b0, 32'h0, t0, lat, err, dout);
      checks++;
      if ({lat, err, dout} !== {32'd3, 1'b0, exp_pop[i]}) begin
        errors++; $display("FAIL lifo_pop%0d: got lat=%0d err=%b dat=%h expected lat=3 err=0 dat=%h", i, lat, err, dout, exp_pop[i]);
      end
    end
    checks++; if ({level, empty} !== {5'd0, 1'b1}) begin errors++; $display("FAIL lifo_drain: got %0d/%b expected 0/1", level, empty); end
    checks++; if (bus.A_DAT_OUT !== 32'h0) begin errors++; $display("FAIL lifo_a_dat_untouched: got %h expected 0", bus.A_DAT_OUT); end
  endtask

  task automatic test_empty_pop();
    int t0, lat, pc; logic err; logic [31:0] dout;
    pc = pop_cnt;
    run_op(1'b1, 1'b0, 32'h0, t0, lat, err, dout);
    checks++;
    if ({lat, err, dout} !== {32'd1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL empty_pop: got lat=%0d err=%b dat=%h expected lat=1 err=1 dat=0", lat, err, dout);
    end
    checks++; if (pop_cnt !== pc) begin errors++; $display("FAIL empty_pop_strobe: got %0d strobes expected %0d", pop_cnt, pc); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL empty_pop_level: got %0d expected 0", level); end
  endtask

  task automatic test_back_to_back();
    int t0, n; int ack_cyc [4]; bit ack_cl [4];
    for (int k = 0; k < 4; k++) begin ack_cyc[k] = -1; ack_cl[k] = 1'b0; end
    do_reset();
    @(negedge clk);
    bus.A_PUSH_STB = 1'b1; bus.A_DAT_IN = 32'hA5A5_0000;
    bus.B_PUSH_STB = 1'b1; bus.B_DAT_IN = 32'hB5B5_0000;
    t0 = cyc; n = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(negedge clk);
      if (bus.A_ACK || bus.B_ACK) begin
        ack_cl[n] = bus.B_ACK; ack_cyc[n] = cyc; n++;
      end
    end
    drop_all();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ack_cl[k] !== bit'(k % 2) || ack_cyc[k] !== t0 + 3 + 4 * k) begin
        errors++; $display("FAIL b2b_ack%0d: got client=%0d cycle=%0d expected client=%0d cycle=%0d",
          k, ack_cl[k], ack_cyc[k], k % 2, t0 + 3 + 4 * k);
      end
    end
    checks++; if (level !== 5'd4) begin errors++; $display("FAIL b2b_level: got %0d expected 4", level); end
    checks++; if ({adj_err, both_ack} !== 2'b00) begin errors++; $display("FAIL b2b_strobe_rules: got adj=%b dual_ack=%b expected 0 0", adj_err, both_ack); end
  endtask

  task automatic test_full();
    int t0, lat, pc; logic err; logic [31:0] dout;
    for (int i = 0; i < 12; i++) run_op(1'b0, 1'b1, 32'h100 + 32'(i), t0, lat, err, dout);
    checks++; if ({level, full} !== {5'd16, 1'b1}) begin errors++; $display("FAIL full_level: got %0d/%b expected 16/1", level, full); end
    pc = push_cnt;
    run_op(1'b0, 1'b1, 32'hDEAD, t0, lat, err, dout);
    checks++;
    if ({lat, err, dout} !== {32'd1, 1'b1, 32'h0}) begin
      errors++; $display("FAIL full_push: got lat=%0d err=%b dat=%h expected lat=1 err=1 dat=0", lat, err, dout);
    end
    checks++; if (push_cnt !== pc) begin errors++; $display("FAIL full_push_strobe: got %0d strobes expected %0d", push_cnt, pc); end
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_push_level: got %0d expected 16", level); end
    run_op(1'b1, 1'b0, 32'h0, t0, lat, err, dout);
    checks++;
    if ({lat, err, dout} !== {32'd3, 1'b0, 32'h10B}) begin
      errors++; $display("FAIL full_pop: got lat=%0d err=%b dat=%h expected lat=3 err=0 dat=0000010b", lat, err, dout);
    end
    run_op(1'b1, 1'b1, 32'h222, t0, lat, err, dout);
    checks++;
    if ({err, dout, level} !== {1'b0, 32'h10B, 5'd16}) begin
      errors++; $display("FAIL push_keeps_dat: got err=%b dat=%h level=%0d expected err=0 dat=0000010b level=16", err, dout, level);
    end
  endtask

  task automatic test_reset_in_issue();
    int t0, lat, n_a, t_a, t_b; logic err; logic [31:0] dout; bit stray;
    run_op(1'b0, 1'b0, 32'h0, t0, lat, err, dout);
    checks++; if ({dout, level} !== {32'h222, 5'd15}) begin errors++; $display("FAIL pre_reset_pop: got dat=%h level=%0d expected 00000222/15", dout, level); end
    @(negedge clk);
    bus.A_PUSH_STB = 1'b1; bus.A_DAT_IN = 32'h333;
    @(negedge clk);
    checks++; if (bus.S_PUSH_STB !== 1'b1) begin errors++; $display("FAIL issue_strobe: got %b expected 1", bus.S_PUSH_STB); end
    rst_n = 1'b0;
    drop_all();
    @(negedge clk);
    rst_n = 1'b1;
    checks++; if ({level, bus.A_DAT_OUT} !== {5'd0, 32'h0}) begin errors++; $display("FAIL reset_issue_state: got level=%0d dat=%h expected 0/0", level, bus.A_DAT_OUT); end
    stray = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.A_ACK || bus.B_ACK || bus.S_PUSH_STB) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL reset_issue_dropped: got stray activity=%b expected 0", stray); end
    bus.A_PUSH_STB = 1'b1; bus.A_DAT_IN = 32'h444;
    bus.B_PUSH_STB = 1'b1; bus.B_DAT_IN = 32'h555;
    t0 = cyc; t_a = -1; t_b = -1; n_a = 0;
    for (int i = 0; i < 20 && t_b < 0; i++) begin
      @(negedge clk);
      if (bus.A_ACK && t_a < 0 && t_b < 0) begin t_a = cyc; bus.A_PUSH_STB = 1'b0; end
      if (bus.B_ACK) begin t_b = cyc; bus.B_PUSH_STB = 1'b0; end
      if (bus.A_ACK) n_a++;
    end
    drop_all();
    checks++; if (t_a !== t0 + 3) begin errors++; $display("FAIL prio_reset_a_first: got A ack cycle %0d expected %0d", t_a, t0 + 3); end
    checks++; if (t_b !== t0 + 7) begin errors++; $display("FAIL prio_reset_b_wait: got B ack cycle %0d expected %0d", t_b, t0 + 7); end
    checks++; if ({n_a, level} !== {32'd1, 5'd2}) begin errors++; $display("FAIL prio_reset_end: got a_acks=%0d level=%0d expected 1/2", n_a, level); end
  endtask

  initial begin
    drop_all();
    bus.A_DAT_IN = '0;
    bus.B_DAT_IN = '0;
    test_reset();
    test_single_push();
    test_lifo_order();
    test_empty_pop();
    test_back_to_back();
    test_full();
    test_reset_in_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
